// File: rtl/q_meas_pkg.sv
// -----------------------------------------------------------------------------
// q_meas_pkg
// Shared definitions for the Q measurement engine and its min/max tracker.
//   q_state_e : measurement FSM state encoding
//   cnt_width : width of the settle/sample counters for a given configuration
// -----------------------------------------------------------------------------
package q_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACQUIRE = 2'd2,
    DONE    = 2'd3
  } q_state_e;

  // One extra count of headroom so a counter can hold the full WINDOW value
  // after the final sample without wrapping.
  function automatic int cnt_width(input int settle_cycles, input int window);
    int m;
    m = (settle_cycles > window) ? settle_cycles : window;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/q_minmax_tracker.sv
// -----------------------------------------------------------------------------
// q_minmax_tracker
// Running minimum / maximum / sample count over a window of unsigned samples.
//   clk, rst : clock, asynchronous active-high reset (clears all to 0)
//   clr      : start a new window (min=all-ones, max=0, count=0); wins over valid
//   valid    : absorb data this cycle
//   data     : unsigned sample
//   min, max : extremes seen since the last clr
//   count    : number of samples absorbed since the last clr
// -----------------------------------------------------------------------------
module q_minmax_tracker #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min   <= '0;
      max   <= '0;
      count <= '0;
    end else if (clr) begin
      min   <= '1;
      max   <= '0;
      count <= '0;
    end else if (valid) begin
      if (data < min) min <= data;
      if (data > max) max <= data;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/q_measure_engine.sv
// -----------------------------------------------------------------------------
// q_measure_engine
// Applies the Q loop reference to the DAC, waits SETTLE_CYCLES for the loop to
// settle, collects WINDOW valid ADC samples and publishes max-min as the Q
// estimate with a one-cycle ready pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : measurement run enable
//   i_ref      : requested current reference
//   adc_valid  : adc_data valid this cycle
//   adc_data   : unsigned ADC sample
//   dac_code   : registered DAC code currently applied
//   q_measured : latest Q estimate, held between updates
//   ready      : one-cycle pulse when q_measured updates
//   busy       : high in SETTLE or ACQUIRE
// Build option: define Q_MEAS_AVG_EN to publish the mean of the current and
// previous window results (first result after reset/abort passes through).
// -----------------------------------------------------------------------------
module q_measure_engine
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic                 adc_valid,
  input  logic [BUS_WIDTH-1:0] adc_data,
  output logic [BUS_WIDTH-1:0] dac_code,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, WINDOW);

  q_state_e             state, state_nxt;
  logic [CNT_W-1:0]     settle_cnt;
  logic [BUS_WIDTH-1:0] trk_min, trk_max;
  logic [CNT_W-1:0]     trk_count;
  logic [BUS_WIDTH-1:0] curr_q, q_next;

  // dac_code doubles as the latched reference; any difference from i_ref
  // while a measurement is in flight means the operating point moved.
  logic ref_change, in_flight, abort, start, settle_done, trk_clr, acq_valid, last_sample;

  assign ref_change  = (i_ref != dac_code);
  assign in_flight   = (state == SETTLE) || (state == ACQUIRE);
  assign abort       = in_flight && enable && ref_change;
  assign start       = (state == IDLE) && enable;
  assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign trk_clr     = (state == SETTLE) && enable && !ref_change && settle_done;
  assign acq_valid   = (state == ACQUIRE) && enable && !ref_change && adc_valid;
  // The WINDOW-th sample is the one absorbed while count still reads WINDOW-1.
  assign last_sample = acq_valid && (trk_count == CNT_W'(WINDOW - 1));
  assign busy        = in_flight;

  q_minmax_tracker #(
    .WIDTH (BUS_WIDTH),
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .clr   (trk_clr),
    .valid (acq_valid),
    .data  (adc_data),
    .min   (trk_min),
    .max   (trk_max),
    .count (trk_count)
  );

  // Only evaluated in DONE, where at least one sample guarantees max >= min.
  assign curr_q = trk_max - trk_min;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE: begin
        if (!enable)          state_nxt = IDLE;
        else if (ref_change)  state_nxt = SETTLE;
        else if (settle_done) state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        if (!enable)          state_nxt = IDLE;
        else if (ref_change)  state_nxt = SETTLE;
        else if (last_sample) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef Q_MEAS_AVG_EN
  logic [BUS_WIDTH-1:0] prev_q;
  logic                 have_prev;
  logic [BUS_WIDTH:0]   avg_sum;

  assign avg_sum = {1'b0, prev_q} + {1'b0, curr_q};
  assign q_next  = have_prev ? avg_sum[BUS_WIDTH:1] : curr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      have_prev <= 1'b0;
    end else if (abort) begin
      have_prev <= 1'b0;
    end else if (state == DONE) begin
      prev_q    <= curr_q;
      have_prev <= 1'b1;
    end
  end
`else
  assign q_next = curr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      dac_code   <= '0;
      q_measured <= '0;
      ready      <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state == DONE);
      if (start || abort) begin
        dac_code   <= i_ref;
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (state == DONE) q_measured <= q_next;
    end
  end

endmodule
